// File: rtl/uart_tx_serializer_if.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer_if
//
// Groups the FIFO-side handshake and the serial line outputs of the UART
// transmit serializer into one bundle.
//
//   fifo_empty     : upstream byte FIFO holds no data
//   fifo_out_valid : one-cycle pulse marking fifo_output as valid
//   fifo_output    : byte returned by the FIFO (WIDTH bits)
//   fifo_read_en   : registered one-cycle read request to the FIFO
//   tx             : registered serial line, idle high
//   tx_busy        : high whenever the serializer is not idle
//
// Modports:
//   master : the serializer (consumes FIFO data, drives tx)
//   slave  : the FIFO / line side
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface uart_tx_serializer_if #(
  parameter int WIDTH = 8
);

  logic             fifo_empty;
  logic             fifo_out_valid;
  logic [WIDTH-1:0] fifo_output;
  logic             fifo_read_en;
  logic             tx;
  logic             tx_busy;

  modport master (
    input  fifo_empty,
    input  fifo_out_valid,
    input  fifo_output,
    output fifo_read_en,
    output tx,
    output tx_busy
  );

  modport slave (
    output fifo_empty,
    output fifo_out_valid,
    output fifo_output,
    input  fifo_read_en,
    input  tx,
    input  tx_busy
  );

endinterface

// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
//
// Pulls bytes from an upstream FIFO and sends them as 8N1-style UART frames
// (start bit, WIDTH data bits LSB first, one stop bit), each bit held for
// CLKS_PER_BIT clock cycles.
//
// Parameters:
//   CLKS_PER_BIT : clk cycles per UART bit (2..65535)
//   WIDTH        : data bits per frame
//
// Ports:
//   clk  : single clock, all state changes on its rising edge
//   rst  : asynchronous, active-high reset; forces the line high at once
//   bus  : uart_tx_serializer_if.master
//            fifo_empty / fifo_out_valid / fifo_output  (in)
//            fifo_read_en / tx / tx_busy                (out)
//
// Flow per byte: IDLE -> REQ (read_en high for one cycle) -> WAIT (up to four
// cycles for the FIFO's valid pulse) -> START -> DATA -> STOP -> IDLE.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int WIDTH        = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_serializer_if.master bus
);

  localparam int               BIT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [15:0]      BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WIDTH - 1);
  // Four WAIT cycles are allowed for the FIFO to answer a read request.
  localparam logic [1:0]       WAIT_LAST = 2'd3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  state_t           state_reg,   state_next;
  logic [15:0]      baud_reg,    baud_next;
  logic [BIT_W-1:0] bit_idx_reg, bit_idx_next;
  logic [WIDTH-1:0] shift_reg,   shift_next;
  logic [1:0]       wait_reg,    wait_next;
  logic             tx_reg,      tx_next;
  logic             read_en_reg, read_en_next;

  // Cleared by reset and set by the first clock edge afterwards. IDLE only
  // issues a read once it is set, so the earliest request after reset
  // release lands on the second rising edge.
  logic             armed_reg;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      baud_reg    <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      wait_reg    <= '0;
      tx_reg      <= 1'b1;
      read_en_reg <= 1'b0;
      armed_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      baud_reg    <= baud_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      wait_reg    <= wait_next;
      tx_reg      <= tx_next;
      read_en_reg <= read_en_next;
      armed_reg   <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and datapath logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    baud_next    = baud_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    wait_next    = wait_reg;
    tx_next      = tx_reg;
    // The read request defaults low, so it can only ever be a single-cycle
    // pulse followed by at least one low cycle (the FIFO edge-detects it).
    read_en_next = 1'b0;

    case (state_reg)
      IDLE: begin
        tx_next = 1'b1;
        if (armed_reg && !bus.fifo_empty) begin
          read_en_next = 1'b1;
          state_next   = REQ;
        end
      end

      REQ: begin
        wait_next  = '0;
        state_next = WAIT;
      end

      WAIT: begin
        // fifo_out_valid is only looked at here; pulses in any other state
        // are ignored.
        if (bus.fifo_out_valid) begin
          shift_next = bus.fifo_output;
          tx_next    = 1'b0;
          baud_next  = '0;
          state_next = START;
        end else if (wait_reg == WAIT_LAST) begin
          tx_next    = 1'b1;
          state_next = IDLE;
        end else begin
          wait_next = wait_reg + 2'd1;
        end
      end

      START: begin
        if (baud_reg == BAUD_LAST) begin
          baud_next    = '0;
          bit_idx_next = '0;
          tx_next      = shift_reg[0];
          state_next   = DATA;
        end else begin
          baud_next = baud_reg + 16'd1;
        end
      end

      DATA: begin
        if (baud_reg == BAUD_LAST) begin
          baud_next = '0;
          if (bit_idx_reg == BIT_LAST) begin
            tx_next    = 1'b1;
            state_next = STOP;
          end else begin
            // Shift right so the next bit to send is always at index 0.
            shift_next   = shift_reg >> 1;
            tx_next      = shift_next[0];
            bit_idx_next = bit_idx_reg + BIT_W'(1);
          end
        end else begin
          baud_next = baud_reg + 16'd1;
        end
      end

      STOP: begin
        tx_next = 1'b1;
        if (baud_reg == BAUD_LAST) begin
          baud_next  = '0;
          state_next = IDLE;
        end else begin
          baud_next = baud_reg + 16'd1;
        end
      end

      default: begin
        tx_next    = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.tx           = tx_reg;
  assign bus.fifo_read_en = read_en_reg;
  // Derived from the state register, which reset clears asynchronously, so
  // tx_busy drops together with the line returning high.
  assign bus.tx_busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_serializer
//
// Directed bench for uart_tx_serializer with CLKS_PER_BIT=4, WIDTH=8.
// A small FIFO responder answers each read request with a configurable
// latency; frames are captured cycle by cycle from tx.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_tx_serializer;

  localparam int CPB = 4;
  localparam int W   = 8;

  logic clk;
  logic rst;

  uart_tx_serializer_if #(.WIDTH(W)) bus ();

  uart_tx_serializer #(
    .CLKS_PER_BIT(CPB),
    .WIDTH       (W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Clock starts late so the reset values can be checked with no edge seen.
  initial begin
    clk = 1'b0;
    #20;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- FIFO responder ----------------
  logic [7:0] fifo_mem [0:15];
  int         rd_ptr;
  int         resp_delay;   // 0 = never answer
  int         resp_cnt;
  logic       resp_valid;
  logic [7:0] resp_data;
  logic       spur_valid;
  logic [7:0] spur_data;

  assign bus.fifo_out_valid = resp_valid | spur_valid;
  assign bus.fifo_output    = resp_valid ? resp_data : spur_data;

  initial begin
    rd_ptr     = 0;
    resp_cnt   = 0;
    resp_valid = 1'b0;
    resp_data  = 8'h00;
    forever begin
      tick();
      resp_valid = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          resp_valid = 1'b1;
          resp_data  = fifo_mem[rd_ptr];
          rd_ptr++;
        end
      end
      if (bus.fifo_read_en && resp_delay != 0 && resp_cnt == 0)
        resp_cnt = resp_delay;
    end
  end

  // ---------------- read_en monitor ----------------
  int   rd_pulses;
  int   rd_long;
  logic rd_prev;

  initial begin
    rd_pulses = 0;
    rd_long   = 0;
    rd_prev   = 1'b0;
    forever begin
      tick();
      if (bus.fifo_read_en && !rd_prev) rd_pulses++;
      if (bus.fifo_read_en && rd_prev)  rd_long++;
      rd_prev = bus.fifo_read_en;
    end
  end

  // ---------------- helpers ----------------
  // Waits for the start bit; on return the current sample is cycle 0 of
  // the frame. idle counts the high samples seen before it.
  task automatic wait_start(input string tag, output int idle);
    logic found;
    found = 1'b0;
    idle  = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (bus.tx == 1'b0) begin
        found = 1'b1;
        break;
      end
      idle++;
    end
    check_val({tag, "_start_seen"}, 32'(found), 32'd1);
  endtask

  // Samples the 40 cycles of a frame (cycle 0 already current). exp_bits is
  // in time order, first bit in the MSB.
  task automatic capture_frame(input string tag, input logic [9:0] exp_bits, input int spur_at);
    logic [9:0] bits;
    int         glitches;
    bits     = '0;
    glitches = 0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) tick();
      spur_valid = (k == spur_at);
      if (k % 4 == 0) bits[9 - k/4] = bus.tx;
      else if (bus.tx !== bits[9 - k/4]) glitches++;
    end
    spur_valid = 1'b0;
    $display("frame %s: tx bits=%b expected=%b", tag, bits, exp_bits);
    check_val({tag, "_bits"}, 32'(bits), 32'(exp_bits));
    check_val({tag, "_hold"}, 32'(glitches), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int idle;
    int base;
    int lows;
    int n;
    logic found;
    logic busy5;

    rst        = 1'b1;
    bus.fifo_empty = 1'b1;
    spur_valid = 1'b0;
    spur_data  = 8'h00;
    resp_delay = 2;
    for (int i = 0; i < 16; i++) fifo_mem[i] = 8'h00;

    // Reset, no clock yet
    #2;
    $display("txn reset: tx=%b read_en=%b busy=%b", bus.tx, bus.fifo_read_en, bus.tx_busy);
    check_val("reset_tx",      32'(bus.tx),           32'd1);
    check_val("reset_read_en", 32'(bus.fifo_read_en), 32'd0);
    check_val("reset_busy",    32'(bus.tx_busy),      32'd0);

    repeat (2) tick();

    // Single byte 0xA5, FIFO answers two cycles after read_en rises
    fifo_mem[0]    = 8'hA5;
    bus.fifo_empty = 1'b0;
    rst            = 1'b0;
    tick();
    check_val("rd_first_edge",  32'(bus.fifo_read_en), 32'd0);
    tick();
    check_val("rd_second_edge", 32'(bus.fifo_read_en), 32'd1);
    bus.fifo_empty = 1'b1;
    wait_start("a5", idle);
    capture_frame("a5", 10'b0101001011, -1);
    tick();
    check_val("a5_busy_after", 32'(bus.tx_busy), 32'd0);
    check_val("a5_tx_after",   32'(bus.tx),      32'd1);
    check_val("a5_rd_pulses",  32'(rd_pulses),   32'd1);

    // Back-to-back 0x00 then 0xFF, FIFO answers in the first WAIT cycle
    resp_delay           = 1;
    fifo_mem[rd_ptr]     = 8'h00;
    fifo_mem[rd_ptr + 1] = 8'hFF;
    base                 = rd_pulses;
    bus.fifo_empty       = 1'b0;
    wait_start("b2b0", idle);
    capture_frame("b2b0", 10'b0000000001, -1);
    wait_start("b2b1", idle);
    bus.fifo_empty = 1'b1;
    $display("txn b2b gap: %0d idle cycles", idle);
    check_val("b2b_gap", 32'(idle), 32'd3);
    capture_frame("b2b1", 10'b0111111111, -1);
    tick();
    check_val("b2b_busy_after", 32'(bus.tx_busy),     32'd0);
    check_val("b2b_rd_pulses",  32'(rd_pulses - base), 32'd2);
    check_val("b2b_rd_long",    32'(rd_long),          32'd0);

    // Missing data: no valid pulse ever arrives
    resp_delay     = 0;
    bus.fifo_empty = 1'b0;
    found          = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.fifo_read_en) begin
        found = 1'b1;
        break;
      end
    end
    check_val("miss_first_req", 32'(found), 32'd1);
    found = 1'b0;
    lows  = 0;
    n     = 0;
    busy5 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (bus.tx == 1'b0) lows++;
      if (n == 5) busy5 = bus.tx_busy;
      if (bus.fifo_read_en) begin
        found = 1'b1;
        break;
      end
    end
    bus.fifo_empty = 1'b1;
    $display("txn missing data: request interval %0d cycles", n);
    check_val("miss_second_req", 32'(found), 32'd1);
    check_val("miss_interval",   32'(n),     32'd6);
    check_val("miss_tx_low",     32'(lows),  32'd0);
    check_val("miss_idle_busy",  32'(busy5), 32'd0);
    repeat (8) tick();
    check_val("miss_settle_busy", 32'(bus.tx_busy), 32'd0);

    // Mid-frame reset during data bit 3 of 0x3C
    resp_delay       = 1;
    fifo_mem[rd_ptr] = 8'h3C;
    base             = rd_pulses;
    bus.fifo_empty   = 1'b0;
    wait_start("rst", idle);
    bus.fifo_empty = 1'b1;
    repeat (17) tick();
    check_val("rst_pre_tx",   32'(bus.tx),      32'd1);
    check_val("rst_pre_busy", 32'(bus.tx_busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    $display("txn mid-frame reset: tx=%b busy=%b", bus.tx, bus.tx_busy);
    check_val("rst_async_tx",      32'(bus.tx),           32'd1);
    check_val("rst_async_busy",    32'(bus.tx_busy),      32'd0);
    check_val("rst_async_read_en", 32'(bus.fifo_read_en), 32'd0);
    repeat (2) tick();
    rst  = 1'b0;
    lows = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.tx == 1'b0 || bus.fifo_read_en) lows++;
    end
    check_val("rst_after_activity", 32'(lows),             32'd0);
    check_val("rst_after_busy",     32'(bus.tx_busy),      32'd0);
    check_val("rst_rd_pulses",      32'(rd_pulses - base), 32'd1);

    // Spurious valid while in DATA, with fifo_output changing under it
    resp_delay       = 1;
    fifo_mem[rd_ptr] = 8'h96;
    base             = rd_pulses;
    spur_data        = 8'h00;
    bus.fifo_empty   = 1'b0;
    wait_start("spur", idle);
    bus.fifo_empty = 1'b1;
    capture_frame("spur", 10'b0011010011, 20);
    lows = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.tx == 1'b0) lows++;
    end
    check_val("spur_no_extra_frame", 32'(lows),             32'd0);
    check_val("spur_busy_after",     32'(bus.tx_busy),      32'd0);
    check_val("spur_rd_pulses",      32'(rd_pulses - base), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
